// File: rtl/dmem_access_ctrl_if.sv
// Request/response handshake between the MEM stage (master) and the data-memory
// access controller (slave).
interface dmem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Load/store initiator for a word-wide RAM with combinational read: sub-word
// stores are read-modify-write, sub-word loads are sign/zero extended.
module dmem_access_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_4000,
  parameter int          DEPTH_WORDS = 16384
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_access_ctrl_if.slave    bus,
  output logic [31:0]          dram_a,
  output logic                 dram_we,
  output logic [31:0]          dram_d,
  input  logic [31:0]          dram_spo
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  // Inclusive last byte of the window, one bit wider so the sum cannot wrap.
  localparam logic [32:0] W_LAST = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS) - 33'd1;

  state_t      r_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_off;
  logic [15:0] r_wdata;
  logic [31:0] r_dram_a;
  logic [31:0] r_dram_d;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_valid;

  logic        w_misalign;
  logic        w_outside;
  logic        w_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  assign w_misalign = (bus.req_size == 2'd1 && bus.req_addr[0]) ||
                      (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00);
  assign w_outside  = (bus.req_addr < BASE_ADDR) || ({1'b0, bus.req_addr} > W_LAST);
  assign w_err      = (bus.req_size == 2'd3) || w_misalign || w_outside;

  always_comb begin
    w_byte      = dram_spo[{r_off, 3'b000} +: 8];
    w_half      = r_off[1] ? dram_spo[31:16] : dram_spo[15:0];
    w_load_data = dram_spo;
    w_merged    = dram_spo;
    case (r_size)
      2'd0: begin
        w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
        w_merged[{r_off, 3'b000} +: 8] = r_wdata[7:0];
      end
      2'd1: begin
        w_load_data = {{16{r_signed & w_half[15]}}, w_half};
        w_merged[{r_off[1], 4'b0000} +: 16] = r_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_size   <= 2'd0;
      r_signed <= 1'b0;
      r_off    <= 2'd0;
      r_wdata  <= 16'd0;
      r_dram_a <= 32'd0;
      r_dram_d <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_we     <= bus.req_we;
            r_size   <= bus.req_size;
            r_signed <= bus.req_signed;
            r_off    <= bus.req_addr[1:0];
            r_wdata  <= bus.req_wdata[15:0];
            r_rdata  <= 32'd0;
            r_err    <= w_err;
            // Rejected requests leave the RAM port exactly as it was.
            if (w_err) begin
              r_valid <= 1'b1;
              r_state <= DONE;
            end else begin
              r_dram_a <= {bus.req_addr[31:2], 2'b00};
              if (bus.req_we && bus.req_size == 2'd2) begin
                r_dram_d <= bus.req_wdata;
                r_state  <= WR;
              end else begin
                r_state <= RD;
              end
            end
          end
        end
        RD: begin
          if (r_we) begin
            r_dram_d <= w_merged;
            r_state  <= WR;
          end else begin
            r_rdata <= w_load_data;
            r_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        WR: begin
          r_valid <= 1'b1;
          r_state <= DONE;
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dram_we       = (r_state == WR);
  assign dram_a        = r_dram_a;
  assign dram_d        = r_dram_d;
  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = r_valid;
  assign bus.rsp_err   = r_err;
  assign bus.rsp_rdata = r_rdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural combinational-read RAM.
module tb_dmem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dram_a;
  logic        dram_we;
  logic [31:0] dram_d;
  logic [31:0] dram_spo;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_access_ctrl_if bus_if ();

  dmem_access_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .dram_a   (dram_a),
    .dram_we  (dram_we),
    .dram_d   (dram_d),
    .dram_spo (dram_spo)
  );

  always #5 clk = ~clk;

  bit   [31:0] mem [0:16383];
  logic [31:0] a_off;
  int          we_cnt = 0;
  int          rv_cnt = 0;
  logic [31:0] last_wa = 32'd0;
  logic [31:0] last_wd = 32'd0;

  assign a_off    = dram_a - 32'h0000_4000;
  assign dram_spo = mem[a_off[15:2]];

  always @(posedge clk) begin
    if (dram_we) begin
      mem[a_off[15:2]] <= dram_d;
      we_cnt  <= we_cnt + 1;
      last_wa <= dram_a;
      last_wd <= dram_d;
    end
  end

  always @(negedge clk) begin
    if (bus_if.rsp_valid) rv_cnt <= rv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One request; latency counts the accept edge as 1. Returns in IDLE.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] lat, output logic [31:0] rd, output logic err);
    @(negedge clk);
    bus_if.req_we     = we;
    bus_if.req_size   = size;
    bus_if.req_signed = sgn;
    bus_if.req_addr   = addr;
    bus_if.req_wdata  = wdata;
    bus_if.req_valid  = 1'b1;
    chk("ready_at_accept", {31'd0, bus_if.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus_if.req_valid = 1'b0;
    lat = 32'hFFFF_FFFF;
    rd  = 32'hX;
    err = 1'bx;
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) begin
        @(posedge clk);
        #1;
      end
      if (bus_if.rsp_valid) begin
        lat = i;
        rd  = bus_if.rsp_rdata;
        err = bus_if.rsp_err;
        break;
      end
    end
    @(posedge clk);
  endtask

  task automatic xact(input string tag, input logic we, input logic [1:0] size,
                      input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                      input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                      input int exp_wr);
    logic [31:0] lat, rd;
    logic        err;
    int          we0;
    we0 = we_cnt;
    do_req(we, size, sgn, addr, wdata, lat, rd, err);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    chk({tag, "_writes"}, we_cnt - we0, exp_wr);
  endtask

  initial begin
    logic [31:0] a_snap;
    int          we0, rv0;

    bus_if.req_valid  = 1'b0;
    bus_if.req_we     = 1'b0;
    bus_if.req_size   = 2'd0;
    bus_if.req_signed = 1'b0;
    bus_if.req_addr   = 32'd0;
    bus_if.req_wdata  = 32'd0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, bus_if.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
    chk("rst_dram_we", {31'd0, dram_we}, 32'd0);
    chk("rst_dram_a", dram_a, 32'd0);
    chk("rst_dram_d", dram_d, 32'd0);
    chk("rst_rdata", bus_if.rsp_rdata, 32'd0);
    rst = 1'b0;

    // Word store / load
    xact("st_w", 1'b1, 2'd2, 1'b0, 32'h4010, 32'hDEADBEEF, 2, 32'd0, 1'b0, 1);
    chk("st_w_addr", last_wa, 32'h4010);
    chk("st_w_data", last_wd, 32'hDEADBEEF);
    xact("ld_w", 1'b0, 2'd2, 1'b1, 32'h4010, 32'd0, 2, 32'hDEADBEEF, 1'b0, 0);

    // Byte read-modify-write and extension
    xact("pre_20", 1'b1, 2'd2, 1'b0, 32'h4020, 32'h11223344, 2, 32'd0, 1'b0, 1);
    xact("st_b", 1'b1, 2'd0, 1'b0, 32'h4022, 32'h000000AA, 3, 32'd0, 1'b0, 1);
    chk("st_b_addr", last_wa, 32'h4020);
    chk("st_b_data", last_wd, 32'h11AA3344);
    chk("st_b_mem", mem[8], 32'h11AA3344);
    xact("ld_bs", 1'b0, 2'd0, 1'b1, 32'h4022, 32'd0, 2, 32'hFFFFFFAA, 1'b0, 0);
    xact("ld_bu", 1'b0, 2'd0, 1'b0, 32'h4022, 32'd0, 2, 32'h000000AA, 1'b0, 0);
    xact("ld_b3", 1'b0, 2'd0, 1'b1, 32'h4023, 32'd0, 2, 32'h00000011, 1'b0, 0);

    // Halfword read-modify-write and extension
    xact("pre_30", 1'b1, 2'd2, 1'b0, 32'h4030, 32'h00008001, 2, 32'd0, 1'b0, 1);
    xact("st_h", 1'b1, 2'd1, 1'b0, 32'h4032, 32'h00007F00, 3, 32'd0, 1'b0, 1);
    chk("st_h_data", last_wd, 32'h7F008001);
    xact("ld_hs", 1'b0, 2'd1, 1'b1, 32'h4030, 32'd0, 2, 32'hFFFF8001, 1'b0, 0);
    xact("ld_hu", 1'b0, 2'd1, 1'b0, 32'h4030, 32'd0, 2, 32'h00008001, 1'b0, 0);
    xact("ld_hs_hi", 1'b0, 2'd1, 1'b1, 32'h4032, 32'd0, 2, 32'h00007F00, 1'b0, 0);

    // Rejected requests: dram_a must not move
    a_snap = dram_a;
    xact("err_w_mis", 1'b0, 2'd2, 1'b0, 32'h4011, 32'd0, 1, 32'd0, 1'b1, 0);
    xact("err_h_mis", 1'b1, 2'd1, 1'b0, 32'h4013, 32'h1234, 1, 32'd0, 1'b1, 0);
    xact("err_low", 1'b0, 2'd2, 1'b0, 32'h3FFC, 32'd0, 1, 32'd0, 1'b1, 0);
    xact("err_high", 1'b0, 2'd2, 1'b0, 32'h14000, 32'd0, 1, 32'd0, 1'b1, 0);
    xact("err_size3", 1'b0, 2'd3, 1'b0, 32'h4000, 32'd0, 1, 32'd0, 1'b1, 0);
    chk("err_dram_a_held", dram_a, a_snap);

    // Last word of the window
    xact("pre_last", 1'b1, 2'd2, 1'b0, 32'h13FFC, 32'hCAFEF00D, 2, 32'd0, 1'b0, 1);
    xact("ld_last", 1'b0, 2'd2, 1'b0, 32'h13FFC, 32'd0, 2, 32'hCAFEF00D, 1'b0, 0);

    // req_valid held high across two requests
    @(negedge clk);
    bus_if.req_we = 1'b1; bus_if.req_size = 2'd2; bus_if.req_signed = 1'b0;
    bus_if.req_addr = 32'h4040; bus_if.req_wdata = 32'h12345678; bus_if.req_valid = 1'b1;
    @(posedge clk);
    #1 bus_if.req_we = 1'b0; bus_if.req_wdata = 32'd0;
    chk("b2b_ready_wr", {31'd0, bus_if.req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("b2b_ready_done", {31'd0, bus_if.req_ready}, 32'd0);
    chk("b2b_rsp1", {31'd0, bus_if.rsp_valid}, 32'd1);
    @(posedge clk); #1;
    chk("b2b_ready_idle", {31'd0, bus_if.req_ready}, 32'd1);
    chk("b2b_rsp1_end", {31'd0, bus_if.rsp_valid}, 32'd0);
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    chk("b2b_accept2", {31'd0, bus_if.req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("b2b_rsp2", {31'd0, bus_if.rsp_valid}, 32'd1);
    chk("b2b_rdata2", bus_if.rsp_rdata, 32'h12345678);
    @(posedge clk);

    // Reset during the read phase of a byte store
    xact("pre_50", 1'b1, 2'd2, 1'b0, 32'h4050, 32'hA5A5A5A5, 2, 32'd0, 1'b0, 1);
    we0 = we_cnt;
    rv0 = rv_cnt;
    @(negedge clk);
    bus_if.req_we = 1'b1; bus_if.req_size = 2'd0; bus_if.req_signed = 1'b0;
    bus_if.req_addr = 32'h4050; bus_if.req_wdata = 32'h3C; bus_if.req_valid = 1'b1;
    @(posedge clk);
    #1 bus_if.req_valid = 1'b0;
    chk("rmw_in_rd", {31'd0, bus_if.req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rmw_rst_writes", we_cnt - we0, 32'd0);
    chk("rmw_rst_rsp", rv_cnt - rv0, 32'd0);
    chk("rmw_rst_mem", mem[20], 32'hA5A5A5A5);
    chk("rmw_rst_ready", {31'd0, bus_if.req_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
